// File: rtl/stall_mem_responder.sv
// rtl/stall_mem_responder.sv - fixed-latency multi-cycle data memory that stalls the core while busy
// Optional ALIGN_CHECK_EN: odd byte addresses complete with an err pulse and touch neither array nor data_out.
module stall_mem_responder #(
  parameter int LATENCY    = 4,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        done,
  output logic        err
);
  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_cnt;
  logic                    r_wr;
  logic [DEPTH_LOG2-1:0]   r_idx;
  logic [15:0]             r_data;
  logic                    r_err;
  logic [15:0]             r_mem [WORDS];
  logic                    w_accept;
  logic                    w_access;
  logic                    w_misaligned;
  logic                    w_unused_addr;

  assign w_unused_addr = ^{addr[15:DEPTH_LOG2+1], addr[0]};

`ifdef ALIGN_CHECK_EN
  assign w_misaligned = addr[0];
  assign err          = done & r_err;
`else
  assign w_misaligned = 1'b0;
  assign err          = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    stall       = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (r_cnt == 4'd0) begin
          w_access    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        // Accepting straight out of DONE keeps back-to-back accesses bubble-free
        if (enable) begin
          w_accept    = 1'b1;
          w_state_nxt = S_BUSY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= 4'd0;
      r_wr   <= 1'b0;
      r_idx  <= '0;
      r_data <= 16'h0000;
      r_err  <= 1'b0;
    end else if (w_accept) begin
      r_cnt  <= CNT_LOAD;
      r_wr   <= wr;
      r_idx  <= addr[DEPTH_LOG2:1];
      r_data <= data_in;
      r_err  <= w_misaligned;
    end else if (r_state == S_BUSY && r_cnt != 4'd0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= 16'h0000;
    end else if (w_access && !r_wr && !r_err) begin
      data_out <= r_mem[r_idx];
    end
  end

  // Array is deliberately outside the reset domain; a reset simply prevents the pending write
  always_ff @(posedge clk) begin
    if (w_access && r_wr && !r_err) begin
      r_mem[r_idx] <= r_data;
    end
  end

endmodule

// File: tb/tb_stall_mem_responder.sv
// tb/tb_stall_mem_responder.sv - randomized bench against a transaction-level reference model
module tb_stall_mem_responder;
  localparam int LAT = 4;
  localparam int DL2 = 8;
  localparam int NW  = 1 << DL2;

  logic        clk     = 1'b0;
  logic        rst     = 1'b1;
  logic        enable  = 1'b0;
  logic        wr      = 1'b0;
  logic [15:0] addr    = 16'h0000;
  logic [15:0] data_in = 16'h0000;
  logic [15:0] data_out;
  logic        stall;
  logic        done;
  logic        err;

  stall_mem_responder #(.LATENCY(LAT), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
    .data_in(data_in), .data_out(data_out), .stall(stall), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted request ages one step per edge; it is stalling for
  // LAT edges, completes on edge LAT, and is visible as done for one cycle after that.
  logic [15:0] m_mem [NW];
  bit          m_active = 1'b0;
  int          m_age    = 0;
  bit          m_wr     = 1'b0;
  bit          m_mis    = 1'b0;
  int          m_idx    = 0;
  logic [15:0] m_data   = 16'h0000;
  logic [15:0] m_dout   = 16'h0000;

  initial for (int i = 0; i < NW; i++) m_mem[i] = 16'h0000;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_active = 1'b0;
      m_age    = 0;
      m_dout   = 16'h0000;
    end else if (m_active && m_age < LAT) begin
      m_age++;
      if (m_age == LAT && !m_mis) begin
        if (m_wr) m_mem[m_idx] = m_data;
        else      m_dout = m_mem[m_idx];
      end
    end else if (enable) begin
      m_active = 1'b1;
      m_age    = 0;
      m_wr     = wr;
      m_idx    = int'(addr >> 1) % NW;
      m_data   = data_in;
`ifdef ALIGN_CHECK_EN
      m_mis    = addr[0];
`else
      m_mis    = 1'b0;
`endif
    end else begin
      m_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("stall", {15'd0, stall}, {15'd0, m_active && m_age < LAT});
    chk("done",  {15'd0, done},  {15'd0, m_active && m_age == LAT});
    chk("err",   {15'd0, err},   {15'd0, m_active && m_age == LAT && m_mis});
    chk("data_out", data_out, m_dout);
  end

  // Issues one request from IDLE/DONE; returns on the negedge where done is high.
  task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d,
                        input bit churn, output int stalls);
    int i;
    @(negedge clk);
    enable = 1'b1; wr = w; addr = a; data_in = d;
    @(negedge clk);
    enable = 1'b0;
    stalls = 0;
    i = 0;
    while (!done && i < 40) begin
      if (stall) stalls++;
      if (churn) begin
        wr      = 1'($urandom);
        addr    = 16'($urandom);
        data_in = 16'($urandom);
      end
      i++;
      @(negedge clk);
    end
    chk("access_timeout", {15'd0, done}, 16'd1);
  endtask

  int          ns;
  int          t_done [3];
  logic [15:0] dv [3];

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("reset_stall", {15'd0, stall}, 16'd0);
    chk("reset_done", {15'd0, done}, 16'd0);
    chk("reset_dout", data_out, 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NW; i++) access(1'b1, 16'(i * 2), 16'h0000, 1'b0, ns);

    access(1'b1, 16'h0010, 16'hBEEF, 1'b0, ns);
    chk("wr_stall_cycles", 16'(ns), 16'd4);
    access(1'b0, 16'h0010, 16'h0000, 1'b0, ns);
    chk("rd_stall_cycles", 16'(ns), 16'd4);
    chk("rd_beef", data_out, 16'hBEEF);

    access(1'b1, 16'h0000, 16'd1, 1'b0, ns);
    access(1'b1, 16'h0002, 16'd2, 1'b0, ns);
    access(1'b1, 16'h0004, 16'd3, 1'b0, ns);
    @(negedge clk);
    enable = 1'b1; wr = 1'b0; addr = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      int i;
      i = 0;
      do begin @(negedge clk); i++; end while (!done && i < 20);
      t_done[k] = cyc;
      dv[k]     = data_out;
      if (k < 2) addr = 16'((k + 1) * 2);
      else       enable = 1'b0;
    end
    chk("b2b_d0", dv[0], 16'd1);
    chk("b2b_d1", dv[1], 16'd2);
    chk("b2b_d2", dv[2], 16'd3);
    chk("b2b_gap01", 16'(t_done[1] - t_done[0]), 16'd5);
    chk("b2b_gap12", 16'(t_done[2] - t_done[1]), 16'd5);

    access(1'b1, 16'h0200, 16'h1234, 1'b0, ns);
    access(1'b0, 16'h0000, 16'h0000, 1'b0, ns);
    chk("wrap_read", data_out, 16'h1234);

    @(negedge clk);
    enable = 1'b1; wr = 1'b1; addr = 16'h0020; data_in = 16'hAAAA;
    @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid_stall", {15'd0, stall}, 16'd0);
    chk("rst_mid_done", {15'd0, done}, 16'd0);
    chk("rst_mid_err", {15'd0, err}, 16'd0);
    chk("rst_mid_dout", data_out, 16'h0000);
    @(negedge clk);
    enable = 1'b1; wr = 1'b0; addr = 16'h0020;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_release_accept", {15'd0, stall}, 16'd1);
    @(negedge clk);
    enable = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("rst_release_done", {15'd0, done}, 16'd1);
    access(1'b0, 16'h0010, 16'h0000, 1'b0, ns);
    access(1'b0, 16'h0020, 16'h0000, 1'b0, ns);
    chk("dropped_write", data_out, 16'h0000);

    access(1'b0, 16'h0004, 16'h0000, 1'b0, ns);
    access(1'b0, 16'h0011, 16'h0000, 1'b0, ns);
`ifdef ALIGN_CHECK_EN
    chk("mis_err", {15'd0, err}, 16'd1);
    chk("mis_dout", data_out, 16'd3);
`else
    chk("mis_err", {15'd0, err}, 16'd0);
    chk("mis_dout", data_out, 16'hBEEF);
`endif

    access(1'b1, 16'h0040, 16'hC0DE, 1'b1, ns);
    access(1'b0, 16'h0040, 16'h0000, 1'b1, ns);
    chk("churn_read", data_out, 16'hC0DE);

    for (int n = 0; n < 300; n++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      access(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), ns);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stall_mem_responder.md
# stall_mem_responder

Multi-cycle data-memory responder that services the processor's single-port memory requests (enable / wr / addr / data_in) with a fixed, parameterised access latency. While the access is in progress it signals stall back to the core. It serves as the drop-in multi-cycle replacement for the ideal single-cycle data memory on the processor's memory stage. Storage is an internal word array with byte addressing on the port.

## Interface
- LATENCY, 4: BUSY cycles per access; legal range 1..15.
- DEPTH_LOG2, 8: log2 of word count (default 256 words = 512 bytes).
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  request valid; sampled only in IDLE or DONE.
- wr  input  1  1 = write, 0 = read; sampled with enable.
- addr  input  16  byte address; word index = addr[DEPTH_LOG2:1].
- data_in  input  16  write data; sampled with enable.
- data_out  output  16  read data register.
- stall  output  1  access in progress; core must hold its request stable.
- done  output  1  one-cycle completion pulse.
- err  output  1  one-cycle misaligned-access pulse, coincident with done.

## Operation
- States: IDLE, BUSY, DONE. Down-counter cnt is 4 bits wide.
- Accept:
  - In IDLE or DONE, an edge with enable=1 latches wr, addr and data_in.
  - It also loads cnt = LATENCY-1 and moves to BUSY.
- Idle paths:
  - IDLE with enable=0 stays IDLE.
  - DONE with enable=0 moves to IDLE.
- BUSY:
  - Each edge with cnt!=0 decrements cnt.
  - The edge with cnt==0 performs the access and moves to DONE.
  - Write: array[idx] <= latched data.
  - Read: data_out <= array[idx].
- Request inputs are ignored in BUSY. Changes to enable/addr/data_in mid-access have no effect on the access already latched.
- data_out holds its value until the next completed read. Writes and errored accesses leave it unchanged.
- Address bits above DEPTH_LOG2 are ignored, so addresses wrap modulo 2^(DEPTH_LOG2+1) bytes.
- Array contents are not cleared by reset. Simulation initial contents are zero.
- Output decode:
  - stall = (state==BUSY).
  - done = (state==DONE).
  - err = (state==DONE) && latched error flag.

## Timing
- Reset values: state=IDLE, cnt=0, data_out=16'h0000, stall=0, done=0, err=0.
- Request accepted at edge E0:
  - stall is high from E0 through E(LATENCY).
  - done is high between E(LATENCY) and E(LATENCY+1).
  - Read data is valid on data_out from E(LATENCY).
- Turnaround:
  - A back-to-back request presented during DONE is accepted at E(LATENCY+1).
  - This gives no idle bubble; throughput is one access per LATENCY+1 cycles.
- Reset mid-access: rst low at any point returns the block to IDLE immediately and clears all outputs.
  - A pending write is dropped and the array is unmodified.
  - A pending read leaves data_out at 0.
- Reset released while enable=1: the request is accepted at the first rising edge with rst=1.

## Configuration
- ALIGN_CHECK_EN defined:
  - A request with addr[0]=1 is accepted and timed normally, but performs no array access and no data_out update.
  - err pulses together with done.
- ALIGN_CHECK_EN undefined:
  - addr[0] is ignored, and the access goes to word addr[DEPTH_LOG2:1].
  - err is tied to 0.

## Test plan
All scenarios use default parameters (LATENCY=4, DEPTH_LOG2=8).
- Write then read: write 16'hBEEF at addr 16'h0010, then read 16'h0010.
  - Each access shows 4 cycles of stall followed by a 1-cycle done pulse.
  - data_out = 16'hBEEF from the read's E4.
- Back-to-back: hold enable=1 continuously for three reads of 0x0000, 0x0002, 0x0004 after preloading 1, 2, 3.
  - Requests are accepted 5 cycles apart.
  - data_out steps 1, 2, 3.
  - stall is never low for more than one cycle between accesses.
- Wrap: write 16'h1234 to addr 16'h0200, then read addr 16'h0000 → 16'h1234.
- Reset mid-write: start a write of 16'hAAAA to 0x0020 and assert rst at E2.
  - All outputs read 0 immediately.
  - A later read of 0x0020 returns the prior value (0).
- Misaligned read of addr 16'h0011:
  - With ALIGN_CHECK_EN: err=1 with done at E4, and data_out is unchanged.
  - Without ALIGN_CHECK_EN: the read returns the word at 0x0010, and err stays 0.
- Input churn: toggle addr, wr and data_in every cycle during BUSY. The completed access matches the values latched at E0.
